// File: rtl/cnt_ctrl_pkg.sv
// Shared types and default widths for the cnt_ctrl run controller.
package cnt_ctrl_pkg;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/cnt_ctrl_if.sv
// Control/status bundle between a run requester (master) and cnt_ctrl (slave).
interface cnt_ctrl_if import cnt_ctrl_pkg::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
);

  logic                 start;
  logic                 abort;
  logic                 hold;
  logic [DIV_WIDTH-1:0] div;
  logic [LEN_WIDTH-1:0] len;
  logic                 en;
  logic                 busy;
  logic                 done;
  logic [LEN_WIDTH-1:0] remain;
  logic                 err;

  modport master (
    output start, abort, hold, div, len,
    input  en, busy, done, remain, err
  );

  modport slave (
    input  start, abort, hold, div, len,
    output en, busy, done, remain, err
  );

endinterface

// File: rtl/cnt_ctrl_presc.sv
// Tick prescaler: counts 0..div and wraps, tick marks the terminal count.
module cnt_ctrl_presc import cnt_ctrl_pkg::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 freeze,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tick = (cnt_q == div);

  // clr wins over freeze so a fresh run always starts counting from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!freeze) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Run controller: issues len enable pulses spaced div+1 cycles apart,
// with level hold, abort, one-cycle done and a sticky start-while-busy error.
module cnt_ctrl import cnt_ctrl_pkg::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  cnt_ctrl_if.slave   ctrl
);

  state_e               state_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [LEN_WIDTH-1:0] remain_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 tick;
  logic                 en;

  // Prescaler sits at zero outside RUN, so entering RUN starts from a clean count
  cnt_ctrl_presc #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != RUN),
    .freeze (ctrl.hold),
    .div    (div_q),
    .tick   (tick)
  );

  assign en = tick && (state_q == RUN) && !ctrl.hold && !ctrl.abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrl.start) begin
            busy_q <= 1'b1;
            if (ctrl.len != '0) begin
              div_q    <= ctrl.div;
              remain_q <= ctrl.len;
              state_q  <= RUN;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ctrl.start) err_q <= 1'b1;
          // abort outranks hold; hold simply suppresses en, freezing remain
          if (ctrl.abort) begin
            remain_q <= '0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else if (en && (remain_q != '0)) begin
            remain_q <= remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          if (ctrl.start) err_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.en     = en;
  assign ctrl.busy   = busy_q;
  assign ctrl.done   = done_q;
  assign ctrl.remain = remain_q;
  assign ctrl.err    = err_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: en/done events are logged by a monitor and
// compared against expected events queued when each run is launched.
module tb_cnt_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   checks = 0;
  int   passes = 0;
  int   ev_seen[$];
  int   ev_exp[$];

  cnt_ctrl_if #(.DIV_WIDTH(8), .LEN_WIDTH(12)) ctrl ();

  cnt_ctrl #(.DIV_WIDTH(8), .LEN_WIDTH(12)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event code: cycle*2 for en, cycle*2+1 for done
  always @(negedge clk) begin
    if (ctrl.en === 1'b1) ev_seen.push_back(cyc * 2);
    if (ctrl.done === 1'b1) ev_seen.push_back(cyc * 2 + 1);
    if (ctrl.busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d, input int l, output int s);
    ctrl.div   = 8'(d);
    ctrl.len   = 12'(l);
    ctrl.start = 1'b1;
    s = cyc + 1;
    step();
    ctrl.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ctrl.busy === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ctrl.en !== 1'b0) $display("FAIL reset_en: got %b expected 0", ctrl.en); else passes++;
    checks++; if (ctrl.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ctrl.busy); else passes++;
    checks++; if (ctrl.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", ctrl.done); else passes++;
    checks++; if (ctrl.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", ctrl.err); else passes++;
    checks++; if (ctrl.remain !== 12'd0) $display("FAIL reset_remain: got %0d expected 0", ctrl.remain); else passes++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_div0();
    int s, e, a, eb, bb;
    bit to;
    eb = ev_seen.size();
    bb = busy_cnt;
    do_start(0, 3, s);
    for (int k = 0; k < 3; k++) ev_exp.push_back((s + k) * 2);
    ev_exp.push_back((s + 3) * 2 + 1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (ctrl.remain !== 12'(3 - k)) $display("FAIL div0_remain[%0d]: got %0d expected %0d", k, ctrl.remain, 3 - k); else passes++;
      step();
    end
    wait_idle(20, to);
    checks++; if (to) $display("FAIL div0_timeout: busy still %b expected 0", ctrl.busy); else passes++;
    checks++; if (busy_cnt - bb !== 4) $display("FAIL div0_busy_cycles: got %0d expected 4", busy_cnt - bb); else passes++;
    checks++; if (ev_seen.size() - eb !== ev_exp.size()) $display("FAIL div0_event_count: got %0d expected %0d", ev_seen.size() - eb, ev_exp.size()); else passes++;
    while (ev_exp.size() > 0) begin
      e = ev_exp.pop_front();
      a = (eb < ev_seen.size()) ? ev_seen[eb] : -1;
      eb++;
      checks++; if (a !== e) $display("FAIL div0_event: got code %0d expected code %0d", a, e); else passes++;
    end
  endtask

  task automatic test_div3();
    int s, e, a, eb, bb;
    bit to;
    eb = ev_seen.size();
    bb = busy_cnt;
    do_start(3, 2, s);
    ev_exp.push_back((s + 3) * 2);
    ev_exp.push_back((s + 7) * 2);
    ev_exp.push_back((s + 8) * 2 + 1);
    wait_idle(30, to);
    checks++; if (to) $display("FAIL div3_timeout: busy still %b expected 0", ctrl.busy); else passes++;
    checks++; if (busy_cnt - bb !== 9) $display("FAIL div3_busy_cycles: got %0d expected 9", busy_cnt - bb); else passes++;
    checks++; if (ev_seen.size() - eb !== ev_exp.size()) $display("FAIL div3_event_count: got %0d expected %0d", ev_seen.size() - eb, ev_exp.size()); else passes++;
    while (ev_exp.size() > 0) begin
      e = ev_exp.pop_front();
      a = (eb < ev_seen.size()) ? ev_seen[eb] : -1;
      eb++;
      checks++; if (a !== e) $display("FAIL div3_event: got code %0d expected code %0d", a, e); else passes++;
    end
  endtask

  task automatic test_hold();
    int s, e, a, eb;
    bit to;
    eb = ev_seen.size();
    do_start(1, 4, s);
    ev_exp.push_back((s + 1) * 2);
    ev_exp.push_back((s + 8) * 2);
    ev_exp.push_back((s + 10) * 2);
    ev_exp.push_back((s + 12) * 2);
    ev_exp.push_back((s + 13) * 2 + 1);
    step();
    step();
    ctrl.hold = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (ctrl.remain !== 12'd3) $display("FAIL hold_remain_frozen: got %0d expected 3", ctrl.remain); else passes++;
    ctrl.hold = 1'b0;
    wait_idle(30, to);
    checks++; if (to) $display("FAIL hold_timeout: busy still %b expected 0", ctrl.busy); else passes++;
    checks++; if (ev_seen.size() - eb !== ev_exp.size()) $display("FAIL hold_event_count: got %0d expected %0d", ev_seen.size() - eb, ev_exp.size()); else passes++;
    while (ev_exp.size() > 0) begin
      e = ev_exp.pop_front();
      a = (eb < ev_seen.size()) ? ev_seen[eb] : -1;
      eb++;
      checks++; if (a !== e) $display("FAIL hold_event: got code %0d expected code %0d", a, e); else passes++;
    end
  endtask

  task automatic test_abort();
    int s, s2, e, a, eb;
    bit to;
    eb = ev_seen.size();
    do_start(2, 10, s);
    ev_exp.push_back((s + 2) * 2);
    ev_exp.push_back((s + 5) * 2);
    for (int k = 0; k < 8; k++) step();
    // abort lands on a tick cycle with hold also raised
    ctrl.abort = 1'b1;
    ctrl.hold  = 1'b1;
    step();
    ctrl.abort = 1'b0;
    ctrl.hold  = 1'b0;
    checks++; if (ctrl.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", ctrl.busy); else passes++;
    checks++; if (ctrl.remain !== 12'd0) $display("FAIL abort_remain: got %0d expected 0", ctrl.remain); else passes++;
    checks++; if (ctrl.done !== 1'b0) $display("FAIL abort_done: got %b expected 0", ctrl.done); else passes++;
    step();
    do_start(0, 1, s2);
    ev_exp.push_back(s2 * 2);
    ev_exp.push_back((s2 + 1) * 2 + 1);
    wait_idle(20, to);
    checks++; if (to) $display("FAIL abort_restart_timeout: busy still %b expected 0", ctrl.busy); else passes++;
    checks++; if (ev_seen.size() - eb !== ev_exp.size()) $display("FAIL abort_event_count: got %0d expected %0d", ev_seen.size() - eb, ev_exp.size()); else passes++;
    while (ev_exp.size() > 0) begin
      e = ev_exp.pop_front();
      a = (eb < ev_seen.size()) ? ev_seen[eb] : -1;
      eb++;
      checks++; if (a !== e) $display("FAIL abort_event: got code %0d expected code %0d", a, e); else passes++;
    end
  endtask

  task automatic test_len0_err();
    int s, e, a, eb, bb;
    bit to;
    eb = ev_seen.size();
    bb = busy_cnt;
    do_start(5, 0, s);
    ev_exp.push_back(s * 2 + 1);
    wait_idle(10, to);
    checks++; if (to) $display("FAIL len0_timeout: busy still %b expected 0", ctrl.busy); else passes++;
    checks++; if (busy_cnt - bb !== 1) $display("FAIL len0_busy_cycles: got %0d expected 1", busy_cnt - bb); else passes++;
    checks++; if (ctrl.err !== 1'b0) $display("FAIL len0_err: got %b expected 0", ctrl.err); else passes++;
    do_start(1, 3, s);
    ev_exp.push_back((s + 1) * 2);
    ev_exp.push_back((s + 3) * 2);
    ev_exp.push_back((s + 5) * 2);
    ev_exp.push_back((s + 6) * 2 + 1);
    step();
    step();
    // restart attempt with different div/len must not disturb the run
    do_start(0, 0, a);
    checks++; if (ctrl.err !== 1'b1) $display("FAIL err_set: got %b expected 1", ctrl.err); else passes++;
    wait_idle(20, to);
    checks++; if (to) $display("FAIL err_run_timeout: busy still %b expected 0", ctrl.busy); else passes++;
    step();
    checks++; if (ctrl.err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", ctrl.err); else passes++;
    checks++; if (ev_seen.size() - eb !== ev_exp.size()) $display("FAIL len0_err_event_count: got %0d expected %0d", ev_seen.size() - eb, ev_exp.size()); else passes++;
    while (ev_exp.size() > 0) begin
      e = ev_exp.pop_front();
      a = (eb < ev_seen.size()) ? ev_seen[eb] : -1;
      eb++;
      checks++; if (a !== e) $display("FAIL len0_err_event: got code %0d expected code %0d", a, e); else passes++;
    end
  endtask

  task automatic test_rst_midrun();
    int s, e, a, eb;
    eb = ev_seen.size();
    do_start(1, 5, s);
    ev_exp.push_back((s + 1) * 2);
    ev_exp.push_back((s + 3) * 2);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    checks++; if (ctrl.en !== 1'b0) $display("FAIL rst_mid_en: got %b expected 0", ctrl.en); else passes++;
    checks++; if (ctrl.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", ctrl.busy); else passes++;
    checks++; if (ctrl.done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", ctrl.done); else passes++;
    checks++; if (ctrl.err !== 1'b0) $display("FAIL rst_mid_err: got %b expected 0", ctrl.err); else passes++;
    checks++; if (ctrl.remain !== 12'd0) $display("FAIL rst_mid_remain: got %0d expected 0", ctrl.remain); else passes++;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++; if (ctrl.busy !== 1'b0) $display("FAIL rst_mid_after_busy: got %b expected 0", ctrl.busy); else passes++;
    checks++; if (ev_seen.size() - eb !== ev_exp.size()) $display("FAIL rst_mid_event_count: got %0d expected %0d", ev_seen.size() - eb, ev_exp.size()); else passes++;
    while (ev_exp.size() > 0) begin
      e = ev_exp.pop_front();
      a = (eb < ev_seen.size()) ? ev_seen[eb] : -1;
      eb++;
      checks++; if (a !== e) $display("FAIL rst_mid_event: got code %0d expected code %0d", a, e); else passes++;
    end
  endtask

  initial begin
    ctrl.start = 1'b0;
    ctrl.abort = 1'b0;
    ctrl.hold  = 1'b0;
    ctrl.div   = '0;
    ctrl.len   = '0;
    test_reset();
    test_div0();
    test_div3();
    test_hold();
    test_abort();
    test_len0_err();
    test_rst_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
